pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed 16-bit between-stage registers (fetch-decode, decode-execute, execute-memory, memory-writeback).
- Adds valid/ready flow control, an optional skid entry, flush-to-bubble and a saturating stall counter.
- One instance sits between each pair of adjacent stages. Each instance carries one packed stage bundle (for example {pc, ir} or {a, b, rd, imm}).

Parameters:
- WIDTH, 16, payload width in bits.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- BUBBLE, 0, payload value driven on out_data after a flush or reset (NOP encoding).
- CNTW, 8, stall counter width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all held entries this cycle (branch/jump squash)
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  stage can accept in_data this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream consumes out_data this cycle
- out_data  output  WIDTH  head entry; BUBBLE when empty after flush/reset
- occupancy  output  2  entries held (0..2; never 2 when SKID=0)
- stall_count  output  CNTW  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset values (sampled on the clock edge while reset=1):
  - state=EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0, stall_count=0.
  - in_ready=1 on the cycle after reset deasserts.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency is 1 cycle from input transfer to out_valid when the stage is empty.
- States (SKID=1): EMPTY, FULL (main valid), SKID (main and skid valid).
  - EMPTY: in_valid -> FULL, main<=in_data. Otherwise stay.
  - FULL, in_valid & out_ready -> FULL, main<=in_data (back-to-back, full throughput).
  - FULL, !in_valid & out_ready -> EMPTY, out_data holds its last value (not forced to BUBBLE).
  - FULL, in_valid & !out_ready -> SKID, skid<=in_data.
  - FULL, neither -> stay.
  - SKID: in_ready=0. out_ready -> FULL, main<=skid. Otherwise stay.
  - in_ready = (state!=SKID), taken from a register; no combinational path from out_ready.
- SKID=0:
  - States are EMPTY and FULL only.
  - in_ready = !out_valid | out_ready (combinational).
  - FULL with in_valid & out_ready reloads main.
- Flush:
  - Highest priority after reset; -> EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0.
  - An in_valid arriving in the flush cycle is dropped, not captured.
  - An output transfer in the flush cycle still counts as consumed by downstream.
  - stall_count is not cleared by flush.
- Ordering: entries leave in arrival order. The skid entry is never overtaken.
- occupancy = EMPTY:0, FULL:1, SKID:2.
- stall_count:
  - +1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNTW-1.
  - Cleared only by reset.
- Reset mid-operation (any state) behaves exactly as reset from idle.
- No X on outputs after the first reset edge.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - NOP_INSTR=16'h0000, used as the default BUBBLE for ir bundles;
  - the standard bundle widths FD_W=32 and DE_W=68.
- One sub-module: sat_counter (WIDTH, inc, clear -> count), reused for stall_count and later performance counters.

Test Plan:
- Streaming (SKID=1, WIDTH=16, out_ready=1): in_data 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> same values on out_data 1 cycle later, back-to-back; in_ready stays 1; stall_count=0.
- Backpressure: push 16'hA000 and 16'hA001 with out_ready=0 -> occupancy=2, in_ready=0, a third word 16'hA002 is not accepted. Then raise out_ready -> A000 then A001 in order; in_ready=1 one cycle after A000 leaves.
- Flush in SKID state with in_valid=1 and in_data=16'hBEEF -> next cycle out_valid=0, out_data=BUBBLE (16'h0000), occupancy=0; BEEF never appears on out_data.
- Stall saturation (CNTW=4): hold out_valid with out_ready=0 for 20 cycles -> stall_count stops at 15. Then flush -> stall_count stays 15. Then reset -> 0.
- SKID=0 mode: out_ready toggles 1,0,1 with continuous in_valid -> in_ready follows out_ready in the same cycle when FULL; occupancy never exceeds 1; no data loss or duplication.
- Reset asserted while in SKID state -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE, stall_count=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the between-stage pipeline registers.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int FD_W = 32;
  localparam int DE_W = 68;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL,
    S_SKID  = ST_SKID
  } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
// Latency: count updates on the edge after inc. No backpressure.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready register between two pipeline stages, optional skid entry, flush-to-bubble.
// Latency: 1 cycle input-to-output when empty. Backpressure: registered in_ready (SKID=1) or combinational (SKID=0).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNTW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_count
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;

  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != S_SKID);
    end
  end

  // in_ready is 1 in EMPTY/FULL except SKID=0 FULL stalled, which the FULL arm covers by not loading.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_valid) begin
            state_d = S_FULL;
            main_d  = in_data;
          end
        end
        S_FULL: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (!in_valid && out_ready) begin
            state_d = S_EMPTY;
          end else if (in_valid && !out_ready && (SKID != 0)) begin
            state_d = S_SKID;
            skid_d  = in_data;
          end
        end
        S_SKID: begin
          if (out_ready) begin
            state_d = S_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNTW)) u_stall_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (out_valid && !out_ready),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: SKID=1 instance (CNTW=4) and SKID=0 instance (nonzero bubble).
module tb_pipe_stage_reg;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [7:0]  b_stall;

  pipe_stage_reg #(.WIDTH(16), .SKID(1), .BUBBLE(16'h0000), .CNTW(4)) u_a (
    .clock(clock), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_count(a_stall)
  );

  pipe_stage_reg #(.WIDTH(16), .SKID(0), .BUBBLE(16'h0013), .CNTW(8)) u_b (
    .clock(clock), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_count(b_stall)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        ov;
    logic [15:0] od;
    logic        ir;
    logic [1:0]  occ;
    logic [7:0]  st;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t va[15];
  vec_t vb[8];

  function automatic vec_t mk(logic fl, logic iv, logic [15:0] id, logic ordy,
                              logic ov, logic [15:0] od, logic ir, logic [1:0] occ, logic [7:0] st);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic fl, input logic iv, input logic [15:0] id, input logic ordy);
    a_flush = fl; a_in_valid = iv; a_in_data = id; a_out_ready = ordy;
  endtask

  task automatic check_a(input string tag, input logic ov, input logic [15:0] od,
                         input logic ir, input logic [1:0] occ, input logic [7:0] st);
    chk({tag, ".a_out_valid"}, 32'(a_out_valid), 32'(ov));
    chk({tag, ".a_out_data"},  32'(a_out_data),  32'(od));
    chk({tag, ".a_in_ready"},  32'(a_in_ready),  32'(ir));
    chk({tag, ".a_occupancy"}, 32'(a_occ),       32'(occ));
    chk({tag, ".a_stall"},     32'(a_stall),     32'(st));
  endtask

  initial begin
    // Stream, backpressure with skid, then flush while holding two entries.
    va[0]  = mk(0, 1, 16'h1111, 1,  0, 16'h0000, 1, 0, 0);
    va[1]  = mk(0, 1, 16'h2222, 1,  1, 16'h1111, 1, 1, 0);
    va[2]  = mk(0, 1, 16'h3333, 1,  1, 16'h2222, 1, 1, 0);
    va[3]  = mk(0, 0, 16'h0000, 1,  1, 16'h3333, 1, 1, 0);
    va[4]  = mk(0, 1, 16'hA000, 0,  0, 16'h3333, 1, 0, 0);
    va[5]  = mk(0, 1, 16'hA001, 0,  1, 16'hA000, 1, 1, 0);
    va[6]  = mk(0, 1, 16'hA002, 0,  1, 16'hA000, 0, 2, 1);
    va[7]  = mk(0, 0, 16'h0000, 1,  1, 16'hA000, 0, 2, 2);
    va[8]  = mk(0, 0, 16'h0000, 1,  1, 16'hA001, 1, 1, 2);
    va[9]  = mk(0, 0, 16'h0000, 1,  0, 16'hA001, 1, 0, 2);
    va[10] = mk(0, 1, 16'hC000, 0,  0, 16'hA001, 1, 0, 2);
    va[11] = mk(0, 1, 16'hC001, 0,  1, 16'hC000, 1, 1, 2);
    va[12] = mk(1, 1, 16'hBEEF, 0,  1, 16'hC000, 0, 2, 3);
    va[13] = mk(0, 0, 16'h0000, 0,  0, 16'h0000, 1, 0, 4);
    va[14] = mk(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 4);

    // SKID=0: continuous in_valid with out_ready toggling; in_ready tracks out_ready when full.
    vb[0] = mk(0, 1, 16'h5001, 1,  0, 16'h0013, 1, 0, 0);
    vb[1] = mk(0, 1, 16'h5002, 1,  1, 16'h5001, 1, 1, 0);
    vb[2] = mk(0, 1, 16'h5003, 0,  1, 16'h5002, 0, 1, 0);
    vb[3] = mk(0, 1, 16'h5003, 1,  1, 16'h5002, 1, 1, 1);
    vb[4] = mk(0, 1, 16'h5004, 0,  1, 16'h5003, 0, 1, 1);
    vb[5] = mk(0, 1, 16'h5004, 1,  1, 16'h5003, 1, 1, 2);
    vb[6] = mk(0, 0, 16'h0000, 1,  1, 16'h5004, 1, 1, 2);
    vb[7] = mk(0, 0, 16'h0000, 1,  0, 16'h5004, 1, 0, 2);

    reset = 1'b1;
    drive_a(0, 0, 16'h0, 0);
    b_flush = 0; b_in_valid = 0; b_in_data = 16'h0; b_out_ready = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_a("reset", 0, 16'h0000, 1, 0, 0);
    chk("reset.b_out_valid", 32'(b_out_valid), 32'(0));
    chk("reset.b_out_data",  32'(b_out_data),  32'(16'h0013));
    chk("reset.b_occupancy", 32'(b_occ),       32'(0));
    chk("reset.b_stall",     32'(b_stall),     32'(0));

    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      drive_a(va[i].fl, va[i].iv, va[i].id, va[i].ordy);
      #1;
      check_a($sformatf("va%0d", i), va[i].ov, va[i].od, va[i].ir, va[i].occ, va[i].st);
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      b_flush = vb[i].fl; b_in_valid = vb[i].iv; b_in_data = vb[i].id; b_out_ready = vb[i].ordy;
      #1;
      chk($sformatf("vb%0d.out_valid", i), 32'(b_out_valid), 32'(vb[i].ov));
      chk($sformatf("vb%0d.out_data", i),  32'(b_out_data),  32'(vb[i].od));
      chk($sformatf("vb%0d.in_ready", i),  32'(b_in_ready),  32'(vb[i].ir));
      chk($sformatf("vb%0d.occupancy", i), 32'(b_occ),       32'(vb[i].occ));
      chk($sformatf("vb%0d.stall", i),     32'(b_stall),     32'(vb[i].st));
    end
    b_in_valid = 0;

    // Stall saturation at 15 with CNTW=4, survives flush, cleared by reset.
    @(negedge clock);
    drive_a(0, 1, 16'hD000, 0);
    @(negedge clock);
    drive_a(0, 0, 16'h0000, 0);
    repeat (20) @(negedge clock);
    #1;
    check_a("sat", 1, 16'hD000, 1, 1, 15);
    @(negedge clock);
    drive_a(1, 0, 16'h0000, 0);
    @(negedge clock);
    drive_a(0, 0, 16'h0000, 0);
    #1;
    check_a("sat_flush", 0, 16'h0000, 1, 0, 15);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_a("sat_reset", 0, 16'h0000, 1, 0, 0);

    // Reset while holding two entries.
    drive_a(0, 1, 16'hE000, 0);
    @(negedge clock);
    drive_a(0, 1, 16'hE001, 0);
    @(negedge clock);
    drive_a(0, 1, 16'hE002, 0);
    #1;
    check_a("pre_rst_skid", 1, 16'hE000, 0, 2, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive_a(0, 0, 16'h0000, 0);
    #1;
    check_a("rst_in_skid", 0, 16'h0000, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
